// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
   localparam int SUB_WIDTH_DEF = 8;
endpackage

// File: rtl/fs_bit_cell.sv
// fs_bit_cell: 1-bit enabled full subtractor, outputs forced low when disabled
module fs_bit_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   input  logic en_i,
   output logic y_o,
   output logic bout_o
);
   assign y_o    = en_i & (a_i ^ b_i ^ bin_i);
   assign bout_o = en_i & ((~a_i & b_i) | (bin_i & ~(a_i ^ b_i)));
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: sequences WIDTH LSB-first passes of a 1-bit subtract cell into a full difference
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);
   localparam int CW = $clog2(WIDTH + 1);
   sub_state_t state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, sr_nx, diff_q, diff_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic br_q, br_d, borrow_q, borrow_d, busy_q, busy_d, done_q, done_d;
   logic shifting, accept, y, bout;
   assign shifting = state_q == SHIFT;
   assign accept   = start && (state_q == IDLE || state_q == DONE);
   fs_bit_cell u_cell (
      .a_i   (sa_q[0]),
      .b_i   (sb_q[0]),
      .bin_i (br_q),
      .en_i  (shifting),
      .y_o   (y),
      .bout_o(bout)
   );
   // new bit enters at the MSB so after WIDTH shifts bit 0 holds the first (LSB) result
   assign sr_nx = WIDTH'({y, sr_q} >> 1);
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sr_d     = sr_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      if (accept) begin
         sa_d    = a;
         sb_d    = b;
         br_d    = 1'b0;
         cnt_d   = '0;
         state_d = SHIFT;
      end else if (shifting) begin
         sa_d  = sa_q >> 1;
         sb_d  = sb_q >> 1;
         sr_d  = sr_nx;
         br_d  = bout;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            diff_d   = sr_nx;
            borrow_d = bout;
            state_d  = DONE;
         end
      end else begin
         state_d = IDLE;
      end
      busy_d = state_d == SHIFT;
      done_d = state_d == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sr_q     <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sr_q     <= sr_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end
   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
endmodule
